blocpu_run_controller: RTL and testbench

//  Sequences one blocpu_core program run: streams program words into core instruction memory,

---
 rtl/blocpu_pkg.sv | 19 +
 rtl/blocpu_sat_counter.sv | 22 ++
 rtl/blocpu_run_controller.sv | 167 ++++++++++++++++
 tb/tb_blocpu_run_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blocpu_pkg.sv
// Shared types and default sizing for the blocpu run controller.
package blocpu_pkg;

  localparam int unsigned INSTR_W      = 12;
  localparam int unsigned IMEM_DEPTH   = 256;
  localparam int unsigned RESET_CYCLES = 4;
  localparam int unsigned CYC_W        = 32;
  localparam int unsigned TIMEOUT_CYC  = 1000000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RST,
    START,
    RUN,
    DONE
  } run_state_t;

endpackage

// File: rtl/blocpu_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module blocpu_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/blocpu_run_controller.sv
// Loads a program into blocpu_core imem, resets, starts and waits for the core to halt.
// Optional run cycle limit enabled by defining BLOCPU_RUN_TIMEOUT_EN.
module blocpu_run_controller #(
  parameter int unsigned INSTR_W      = blocpu_pkg::INSTR_W,
  parameter int unsigned IMEM_DEPTH   = blocpu_pkg::IMEM_DEPTH,
  parameter int unsigned RESET_CYCLES = blocpu_pkg::RESET_CYCLES,
  parameter int unsigned CYC_W        = blocpu_pkg::CYC_W
`ifdef BLOCPU_RUN_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC  = blocpu_pkg::TIMEOUT_CYC
`endif
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          load_start,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [INSTR_W-1:0]            load_data,
  input  logic                          load_last,
  input  logic                          abort,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  output logic [INSTR_W-1:0]            imem_wdata,
  output logic                          core_reset,
  output logic                          core_run,
  input  logic                          core_running,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [CYC_W-1:0]              cycles
);

  import blocpu_pkg::*;

  localparam int unsigned ADDR_W = $clog2(IMEM_DEPTH);
  localparam int unsigned RST_W  = $clog2(RESET_CYCLES + 1);

  run_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               ovf_q, ovf_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic               err_d;
  logic               we_d;
  logic [ADDR_W-1:0]  waddr_d;
  logic [INSTR_W-1:0] wdata_d;
  logic               cyc_clr;
  logic               beat;

  assign beat = load_valid && load_ready;

`ifdef BLOCPU_RUN_TIMEOUT_EN
  logic timeout;
  // cycles is about to reach the limit on this RUN edge
  assign timeout = (cycles >= CYC_W'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ovf_d     = ovf_q;
    rst_cnt_d = rst_cnt_q;
    err_d     = err;
    we_d      = 1'b0;
    waddr_d   = imem_addr;
    wdata_d   = imem_wdata;
    cyc_clr   = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (load_start) begin
            state_d = LOAD;
            addr_d  = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            cyc_clr = 1'b1;
          end
        end
        LOAD: begin
          if (beat) begin
            // once overflowed, remaining words are drained without writing
            if (!ovf_q) begin
              we_d    = 1'b1;
              waddr_d = addr_q;
              wdata_d = load_data;
              addr_d  = addr_q + ADDR_W'(1);
              if (!load_last && (addr_q == ADDR_W'(IMEM_DEPTH - 1))) begin
                ovf_d = 1'b1;
                err_d = 1'b1;
              end
            end
            if (load_last) begin
              state_d   = ovf_q ? IDLE : RST;
              rst_cnt_d = '0;
            end
          end
        end
        RST: begin
          if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
            state_d = START;
          end else begin
            rst_cnt_d = rst_cnt_q + RST_W'(1);
          end
        end
        START: begin
          if (core_running) state_d = RUN;
        end
        RUN: begin
          if (!core_running) state_d = DONE;
`ifdef BLOCPU_RUN_TIMEOUT_EN
          if (timeout) begin
            state_d = DONE;
            err_d   = 1'b1;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      ovf_q      <= 1'b0;
      rst_cnt_q  <= '0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      load_ready <= 1'b0;
      core_reset <= 1'b1;
      core_run   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ovf_q      <= ovf_d;
      rst_cnt_q  <= rst_cnt_d;
      err        <= err_d;
      imem_we    <= we_d;
      imem_addr  <= waddr_d;
      imem_wdata <= wdata_d;
      load_ready <= (state_d == LOAD);
      core_reset <= !(state_d inside {START, RUN});
      core_run   <= (state_d inside {START, RUN});
      busy       <= !(state_d inside {IDLE, DONE});
      done       <= (state_d == DONE);
    end
  end

  blocpu_sat_counter #(
    .W(CYC_W)
  ) u_cycles (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cyc_clr),
    .en     (state_q == RUN),
    .count  (cycles)
  );

endmodule

// File: tb/tb_blocpu_run_controller.sv
// Scoreboard bench for blocpu_run_controller: default-depth instance and a 4-word instance.
module tb_blocpu_run_controller;

  logic clk;
  logic reset_n;

  logic        a_load_start, a_load_valid, a_load_ready, a_load_last, a_abort;
  logic [11:0] a_load_data, a_imem_wdata;
  logic        a_imem_we, a_core_reset, a_core_run, a_core_running;
  logic [7:0]  a_imem_addr;
  logic        a_busy, a_done, a_err;
  logic [31:0] a_cycles;

  logic        b_load_start, b_load_valid, b_load_ready, b_load_last, b_abort;
  logic [11:0] b_load_data, b_imem_wdata;
  logic        b_imem_we, b_core_reset, b_core_run, b_core_running;
  logic [1:0]  b_imem_addr;
  logic        b_busy, b_done, b_err;
  logic [31:0] b_cycles;

  int n_cmp = 0;
  int n_bad = 0;
  int halt_after = 10;
  logic a_done_prev = 1'b0;

  logic [19:0] a_wq[$];
  logic [19:0] b_wq[$];
  logic [32:0] a_dq[$];

  blocpu_run_controller #(
    .RESET_CYCLES(4)
`ifdef BLOCPU_RUN_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(20)
`endif
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .load_start(a_load_start), .load_valid(a_load_valid),
    .load_ready(a_load_ready), .load_data(a_load_data), .load_last(a_load_last),
    .abort(a_abort), .imem_we(a_imem_we), .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
    .core_reset(a_core_reset), .core_run(a_core_run), .core_running(a_core_running),
    .busy(a_busy), .done(a_done), .err(a_err), .cycles(a_cycles)
  );

  blocpu_run_controller #(
    .IMEM_DEPTH(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .load_start(b_load_start), .load_valid(b_load_valid),
    .load_ready(b_load_ready), .load_data(b_load_data), .load_last(b_load_last),
    .abort(b_abort), .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
    .core_reset(b_core_reset), .core_run(b_core_run), .core_running(b_core_running),
    .busy(b_busy), .done(b_done), .err(b_err), .cycles(b_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write and completion monitors
  always @(negedge clk) begin : mon_a
    logic [19:0] ew;
    logic [32:0] ed;
    if (a_imem_we) begin
      if (a_wq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_write: unexpected write addr 0x%0h data 0x%0h", a_imem_addr, a_imem_wdata);
      end else begin
        ew = a_wq.pop_front();
        chk("a_write", {13'd0, a_imem_addr, a_imem_wdata}, {13'd0, ew});
      end
    end
    if (a_done && !a_done_prev) begin
      if (a_dq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_done: unexpected completion cycles %0d err %0d", a_cycles, a_err);
      end else begin
        ed = a_dq.pop_front();
        chk("a_done_cycles", {1'b0, a_cycles}, {1'b0, ed[31:0]});
        chk("a_done_err", {32'd0, a_err}, {32'd0, ed[32]});
        chk("a_done_core_run", {32'd0, a_core_run}, 33'd0);
      end
    end
    a_done_prev = a_done;
  end

  always @(negedge clk) begin : mon_b
    logic [19:0] ew;
    if (b_imem_we) begin
      if (b_wq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_write: unexpected write addr 0x%0h data 0x%0h", b_imem_addr, b_imem_wdata);
      end else begin
        ew = b_wq.pop_front();
        chk("b_write", {13'd0, 6'd0, b_imem_addr, b_imem_wdata}, {13'd0, ew});
      end
    end
  end

  // Core model: raises running when asked to run; halts after halt_after cycles or when run drops
  initial begin
    a_core_running = 1'b0;
    forever begin
      @(negedge clk);
      if (a_core_run && !a_core_running) begin
        a_core_running = 1'b1;
        if (halt_after != 0) begin
          repeat (halt_after) @(posedge clk);
          @(negedge clk);
        end else begin
          while (a_core_run) @(negedge clk);
        end
        a_core_running = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic a_load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_load_valid = 1'b1;
      a_load_data  = 12'(base + i * 37);
      a_load_last  = (i == n - 1);
      a_wq.push_back({8'(i), 12'(base + i * 37)});
    end
    @(negedge clk);
    a_load_valid = 1'b0;
    a_load_last  = 1'b0;
  endtask

  task automatic a_begin_load();
    @(negedge clk); a_load_start = 1'b1;
    @(negedge clk); a_load_start = 1'b0;
  endtask

  initial begin
    int n;
    a_load_start = 0; a_load_valid = 0; a_load_last = 0; a_abort = 0; a_load_data = '0;
    b_load_start = 0; b_load_valid = 0; b_load_last = 0; b_abort = 0; b_load_data = '0;
    b_core_running = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_load_ready", {32'd0, a_load_ready}, 33'd0);
    chk("rst_imem_we", {32'd0, a_imem_we}, 33'd0);
    chk("rst_imem_addr", {25'd0, a_imem_addr}, 33'd0);
    chk("rst_imem_wdata", {21'd0, a_imem_wdata}, 33'd0);
    chk("rst_core_reset", {32'd0, a_core_reset}, 33'd1);
    chk("rst_core_run", {32'd0, a_core_run}, 33'd0);
    chk("rst_busy_done_err", {30'd0, a_busy, a_done, a_err}, 33'd0);
    chk("rst_cycles", {1'b0, a_cycles}, 33'd0);

    @(negedge clk); reset_n = 1'b1;

    // 8-word program, halt after 10 run cycles
    a_begin_load();
    chk("load_ready", {31'd0, a_load_ready, a_busy}, 33'd3);
    a_load(8, 12'h5A0);
    n = 0;
    while (a_core_reset && !a_core_run && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("rst_len", 33'(n), 33'd4);
    chk("start_core_run", {31'd0, a_core_run, a_core_reset}, 33'd2);
    a_dq.push_back({1'b0, 32'd10});
    n = 0;
    while (!a_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("run_done_seen", {32'd0, a_done}, 33'd1);
    chk("done_state", {31'd0, a_core_reset, a_busy}, 33'd2);

    // Second run aborted mid-RUN; cycles must start from zero again
    halt_after = 0;
    a_begin_load();
    chk("reload_clears", {a_done, a_cycles}, 33'd0);
    a_load(2, 12'h130);
    n = 0;
    while (!a_core_run && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk("mid_run", {31'd0, a_busy, a_core_run}, 33'd3);
    a_abort = 1'b1;
    @(negedge clk); a_abort = 1'b0;
    chk("abort_state", {29'd0, a_busy, a_core_reset, a_core_run, a_done}, 33'd4);
    chk("abort_err", {32'd0, a_err}, 33'd0);

    // load_valid outside LOAD is ignored
    a_load_valid = 1'b1; a_load_data = 12'hFFF;
    repeat (3) @(negedge clk);
    chk("idle_not_ready", {32'd0, a_load_ready}, 33'd0);
    a_load_valid = 1'b0;

    // abort beats load_start
    a_abort = 1'b1; a_load_start = 1'b1;
    @(negedge clk); a_abort = 1'b0; a_load_start = 1'b0;
    chk("abort_wins", {31'd0, a_busy, a_load_ready}, 33'd0);

`ifdef BLOCPU_RUN_TIMEOUT_EN
    // core never halts: run limit ends it
    a_begin_load();
    a_load(1, 12'h777);
    a_dq.push_back({1'b1, 32'd20});
    n = 0;
    while (!a_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_done_seen", {32'd0, a_done}, 33'd1);
    chk("timeout_core_reset", {32'd0, a_core_reset}, 33'd1);
`endif

    // 4-deep instance: 6 words overflow, only 4 written
    @(negedge clk); b_load_start = 1'b1;
    @(negedge clk); b_load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b_load_valid = 1'b1;
      b_load_data  = 12'(12'h300 + i);
      b_load_last  = (i == 5);
      if (i < 4) b_wq.push_back({8'(i), 12'(12'h300 + i)});
      @(negedge clk);
    end
    b_load_valid = 1'b0; b_load_last = 1'b0;
    chk("ovf_err", {32'd0, b_err}, 33'd1);
    chk("ovf_idle", {30'd0, b_busy, b_load_ready, b_core_run}, 33'd0);

    // exactly 4 words ending on the last address is not an overflow
    b_load_start = 1'b1;
    @(negedge clk); b_load_start = 1'b0;
    chk("b_err_cleared", {31'd0, b_err, b_busy}, 33'd1);
    for (int i = 0; i < 4; i++) begin
      b_load_valid = 1'b1;
      b_load_data  = 12'(12'h0C0 + i);
      b_load_last  = (i == 3);
      b_wq.push_back({8'(i), 12'(12'h0C0 + i)});
      @(negedge clk);
    end
    b_load_valid = 1'b0; b_load_last = 1'b0;
    chk("fill_rst", {30'd0, b_err, b_busy, b_core_reset}, 33'd3);
    b_abort = 1'b1;
    @(negedge clk); b_abort = 1'b0;
    chk("b_abort", {32'd0, b_busy}, 33'd0);

    repeat (3) @(negedge clk);
    chk("a_wq_empty", 33'(a_wq.size()), 33'd0);
    chk("b_wq_empty", 33'(b_wq.size()), 33'd0);
    chk("a_dq_empty", 33'(a_dq.size()), 33'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
